// File: rtl/vga_pkg.sv
// Shared types and raster constants for the VGA framebuffer arbiter.
//   pixel_t   : one RGB332 framebuffer word
//   fb_addr_t : framebuffer word address
//   H_ACTIVE/V_ACTIVE : visible raster size from the VGA timing generator
//   FB_W/FB_H/FB_WORDS : downscaled framebuffer geometry
//   SCALE_LOG2 : log2 of the raster-to-framebuffer downscale factor
package vga_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int FB_WORDS   = FB_W * FB_H;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = 15;

  typedef logic [7:0]        pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer bus into the framebuffer arbiter.
//   wrValid   : writer has a word to store
//   wrReady   : write buffer can take a word this cycle
//   wrAddr    : framebuffer word address
//   wrData    : RGB332 pixel
//   wrDropped : one-cycle pulse when a buffered out-of-range write is discarded
// master = writer side, slave = arbiter side.
interface vga_fb_arbiter_if #(parameter int ADDR_W = 15);
  import vga_pkg::pixel_t;

  logic              wrValid;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddr;
  pixel_t            wrData;
  logic              wrDropped;

  modport master (output wrValid, wrAddr, wrData, input wrReady, wrDropped);
  modport slave  (input wrValid, wrAddr, wrData, output wrReady, wrDropped);
endinterface

// File: rtl/vga_wr_fifo.sv
// Write buffer holding {addr, data} entries in acceptance order.
//   clk, rst_n           : clock, synchronous active-low flush
//   push, push_addr/data : enqueue (caller guarantees !full)
//   pop                  : dequeue the head (caller guarantees !empty)
//   head_addr/head_data  : current head entry, combinational
//   full, empty          : occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable
// when the index bits match.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  pixel_t        push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output pixel_t        head_data,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    pixel_t        data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-2:0]] <= '{addr: push_addr, data: push_data};
  end

  assign head_addr = mem[rd_ptr[PW-2:0]].addr;
  assign head_data = mem[rd_ptr[PW-2:0]].data;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between the display fetch and a
// buffered pixel writer. The display owns every 4th pixel of active video
// (its read slot); buffered writes drain in all other cycles.
//   Clock, Reset_n      : system clock, synchronous active-low reset
//   nextX/nextY/blank_n : raster position from the VGA timing generator
//   wr                  : writer bus (slave side)
//   memAddr/memWe/memWData/memRData : RAM port, read data one cycle late
//   pixel, pixelBlank_n : display output, two cycles behind nextX/nextY
module vga_fb_arbiter
  import vga_pkg::pixel_t;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [10:0]       nextX,
  input  logic [9:0]        nextY,
  input  logic              blank_n,
  vga_fb_arbiter_if.slave   wr,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output pixel_t            memWData,
  input  pixel_t            memRData,
  output pixel_t            pixel,
  output logic              pixelBlank_n
);
  localparam int SL = vga_pkg::SCALE_LOG2;

  logic              slot, slot_q;
  logic [10:0]       xs;
  logic [9:0]        ys;
  logic [ADDR_W-1:0] disp_addr, head_addr, addr_n, addr_q;
  pixel_t            head_data, wdata_n, wdata_q, pix_q;
  logic              full, empty, push, pop, we, drop;
  logic [1:0]        blank_pipe;

  // Display read slot: first of each 4-pixel group inside the visible area.
  assign slot = blank_n &&
                (nextX < 11'(vga_pkg::H_ACTIVE)) &&
                (nextY < 10'(vga_pkg::V_ACTIVE)) &&
                (nextX[SL-1:0] == '0);

  // y*160 as two shifts; result truncates to the address width.
  assign xs        = nextX >> SL;
  assign ys        = nextY >> SL;
  assign disp_addr = (ADDR_W'(ys) << 7) + (ADDR_W'(ys) << 5) + ADDR_W'(xs);

  // Push is registered inside the FIFO, so a word can never reach the
  // RAM in its own acceptance cycle.
  assign push       = wr.wrValid && !full;
  assign wr.wrReady = Reset_n && !full;

  vga_wr_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .push      (push),
    .push_addr (wr.wrAddr),
    .push_data (wr.wrData),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // RAM port mux. Idle cycles and dropped writes keep the previous
  // address/data on the bus.
  always_comb begin
    pop     = 1'b0;
    drop    = 1'b0;
    we      = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    if (slot) begin
      addr_n = disp_addr;
    end else if (!empty) begin
      pop = 1'b1;
      if (int'(head_addr) < FB_W * FB_H) begin
        we      = 1'b1;
        addr_n  = head_addr;
        wdata_n = head_data;
      end else begin
        drop = 1'b1;
      end
    end
    if (!Reset_n) begin
      pop     = 1'b0;
      drop    = 1'b0;
      we      = 1'b0;
      addr_n  = '0;
      wdata_n = '0;
    end
  end

  assign memAddr      = addr_n;
  assign memWe        = we;
  assign memWData     = wdata_n;
  assign wr.wrDropped = drop;

  // slot_q marks the cycle in which memRData carries the slot's word;
  // pix_q holds it for the following 4 pixels.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      slot_q     <= 1'b0;
      pix_q      <= '0;
      blank_pipe <= '0;
    end else begin
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      slot_q     <= slot;
      blank_pipe <= {blank_pipe[0], blank_n};
      if (slot_q) pix_q <= memRData;
    end
  end

  assign pixelBlank_n = Reset_n && blank_pipe[1];
  assign pixel        = pixelBlank_n ? pix_q : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int DEPTH = 4;
  localparam int WORDS = 19200;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic        blank_n;
  logic [14:0] memAddr;
  logic        memWe;
  pixel_t      memWData, memRData, pixel;
  logic        pixelBlank_n;

  vga_fb_arbiter_if #(.ADDR_W(15)) bus();

  vga_fb_arbiter #(.FIFO_DEPTH(DEPTH), .FB_W(160), .FB_H(120), .ADDR_W(15)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .nextX        (nextX),
    .nextY        (nextY),
    .blank_n      (blank_n),
    .wr           (bus.slave),
    .memAddr      (memAddr),
    .memWe        (memWe),
    .memWData     (memWData),
    .memRData     (memRData),
    .pixel        (pixel),
    .pixelBlank_n (pixelBlank_n)
  );

  always #5 Clock = ~Clock;

  // Environment RAM: synchronous read, one cycle latency.
  logic [7:0] ram [32768];
  always @(posedge Clock) begin
    if (memWe) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  // Reference model state: pending write queue, expected framebuffer image,
  // expected display pipeline.
  typedef struct { int a; int d; } ent_t;
  ent_t q[$];
  int   gold [32768];
  int   lastA = 0, lastD = 0, mrd = 0, mpix = 0;
  bit   b1 = 0, b2 = 0, pslot = 0;

  int n_cmp = 0, n_bad = 0;
  int o_addr, o_pix, o_we, o_drop, o_rdy;
  bit o_slot;

  task automatic chk(string tag, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: inputs already applied after the falling edge.
  task automatic cyc();
    bit slot, eWe, eDrop, pop, eRdy, eBl, sv;
    int eAddr, eWd, ePix, sa, sd;
    #1;
    slot  = blank_n && (nextX < 640) && (nextY < 480) && (nextX % 4 == 0);
    eWe   = 0; eDrop = 0; pop = 0;
    eAddr = lastA; eWd = lastD;
    eRdy  = (q.size() < DEPTH);
    if (slot) eAddr = (nextY / 4) * 160 + nextX / 4;
    else if (q.size() > 0) begin
      pop = 1;
      if (q[0].a < WORDS) begin eWe = 1; eAddr = q[0].a; eWd = q[0].d; end
      else eDrop = 1;
    end
    eBl  = b2;
    ePix = b2 ? mpix : 0;
    if (!Reset_n) begin
      eRdy = 0; eWe = 0; eDrop = 0; eAddr = 0; eWd = 0; eBl = 0; ePix = 0;
    end
    chk("wrReady",      int'(bus.wrReady),    int'(eRdy));
    chk("memWe",        int'(memWe),          int'(eWe));
    chk("memAddr",      int'(memAddr),        eAddr);
    chk("memWData",     int'(memWData),       eWd);
    chk("wrDropped",    int'(bus.wrDropped),  int'(eDrop));
    chk("pixel",        int'(pixel),          ePix);
    chk("pixelBlank_n", int'(pixelBlank_n),   int'(eBl));
    o_addr = int'(memAddr); o_pix = int'(pixel); o_we = int'(memWe);
    o_drop = int'(bus.wrDropped); o_rdy = int'(bus.wrReady); o_slot = slot;
    sv = bus.wrValid; sa = int'(bus.wrAddr); sd = int'(bus.wrData);
    @(posedge Clock);
    if (!Reset_n) begin
      q.delete();
      lastA = 0; lastD = 0; b1 = 0; b2 = 0; mpix = 0; pslot = 0;
    end else begin
      if (pslot) mpix = mrd;
      mrd = gold[eAddr];
      if (eWe) gold[eAddr] = eWd;
      if (pop) void'(q.pop_front());
      if (sv && eRdy) q.push_back('{a: sa, d: sd});
      b2 = b1; b1 = blank_n; pslot = slot;
      lastA = eAddr; lastD = eWd;
    end
    @(negedge Clock);
  endtask

  initial begin
    int n, nw, bad;
    int order[$];
    for (int a = 0; a < 32768; a++) begin
      ram[a]  = 8'(a);
      gold[a] = a % 256;
    end
    Reset_n = 0; nextX = 0; nextY = 0; blank_n = 0;
    bus.wrValid = 0; bus.wrAddr = 0; bus.wrData = 0;
    @(negedge Clock);

    // Reset held two cycles, then released.
    cyc(); cyc();
    chk("rst_ready", o_rdy, 0);
    chk("rst_addr", o_addr, 0);
    Reset_n = 1;
    cyc();
    chk("ready_after_rst", o_rdy, 1);

    // Display fetch of word 162 and its 4-pixel hold.
    blank_n = 1; nextY = 10'd4;
    for (int i = 0; i < 6; i++) begin
      nextX = 11'(8 + i);
      cyc();
      if (i == 0) begin chk("fetch_addr", o_addr, 162); chk("fetch_we", o_we, 0); end
      if (i >= 2) chk("fetch_pix", o_pix, 'hA2);
    end

    // Write during active video, then read it back through the display.
    nextY = 0; nextX = 0;
    bus.wrValid = 1; bus.wrAddr = 15'h50; bus.wrData = 8'h3C;
    cyc();
    bus.wrValid = 0;
    n = 0; nw = 0;
    for (int i = 1; i < 16; i++) begin
      nextX = 11'(i);
      cyc();
      if (o_slot && o_we != 0) n++;
      nw += o_we;
    end
    chk("we_in_slot", n, 0);
    chk("write_seen", nw, 1);
    for (int i = 0; i < 4; i++) begin
      nextX = 11'(320 + i);
      cyc();
      if (i >= 2) chk("readback", o_pix, 'h3C);
    end

    // Back-pressure: every cycle is a display slot, so nothing drains.
    nextX = 0; nextY = 0; blank_n = 1;
    bus.wrValid = 1; n = 0;
    for (int i = 0; i < 8; i++) begin
      bus.wrAddr = 15'(1000 + i); bus.wrData = 8'(16 + i);
      cyc();
      if (o_rdy != 0) n++;
    end
    chk("bp_accepts", n, 4);
    chk("bp_stalled", o_rdy, 0);
    bus.wrValid = 0; blank_n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (o_we != 0) order.push_back(o_addr);
    end
    chk("bp_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk("bp_order", order[k], 1000 + k);

    // Out-of-range write is dropped exactly once.
    bus.wrValid = 1; bus.wrAddr = 15'd19200; bus.wrData = 8'h77;
    n = 0; nw = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.wrValid = 0;
      n += o_drop; nw += o_we;
    end
    chk("oor_drop", n, 1);
    chk("oor_we", nw, 0);

    // Mid-operation reset discards queued writes.
    blank_n = 1; nextX = 0; nextY = 0;
    bus.wrValid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.wrAddr = 15'(2000 + i); bus.wrData = 8'hEE;
      cyc();
    end
    bus.wrValid = 0;
    Reset_n = 0;
    cyc();
    Reset_n = 1; blank_n = 0; nw = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      nw += o_we;
    end
    chk("rst_flush_we", nw, 0);
    chk("rst_flush_ready", o_rdy, 1);

    // Randomized raster with random writer traffic.
    nextX = 0; nextY = 10'($urandom_range(0, 479));
    for (int c = 0; c < 3000; c++) begin
      blank_n = (nextX < 640) && (nextY < 480);
      bus.wrValid = ($urandom % 3) != 0;
      bus.wrAddr  = ($urandom % 16 == 0) ? 15'(19200 + $urandom % 13568)
                                         : 15'($urandom % 19200);
      bus.wrData  = 8'($urandom);
      cyc();
      if (nextX == 11'd799) begin
        nextX = 0;
        nextY = (nextY == 10'd524) ? 10'd0 : nextY + 10'd1;
      end else begin
        nextX = nextX + 11'd1;
      end
      if ($urandom % 64 == 0) nextY = 10'($urandom_range(0, 524));
    end

    // Drain and compare the whole RAM image.
    bus.wrValid = 0; blank_n = 0;
    for (int i = 0; i < 10; i++) cyc();
    bad = 0;
    for (int a = 0; a < 32768; a++) if (int'(ram[a]) != gold[a]) bad++;
    chk("ram_image", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
